// File: rtl/relu_pool_requant.sv
// Streaming max-pool (Pool_Dim x Pool_Dim, stride Pool_Dim) with 16->8 bit shift/saturate requantization.
// Optional macro POOL_SAT_COUNT_EN adds a saturating count of clipped outputs on port sat_count.
module relu_pool_requant #(
  parameter int In_Dim   = 4,
  parameter int Pool_Dim = 2,
  parameter int Shift    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_pixel,
  input  logic        in_valid,
  input  logic        clear,
  output logic [7:0]  out_pixel,
  output logic        out_valid,
  output logic        frame_done
`ifdef POOL_SAT_COUNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  localparam int CW = $clog2(In_Dim) + 1;
  localparam int NW = In_Dim / Pool_Dim;
  localparam int PW = (Pool_Dim > 1) ? $clog2(Pool_Dim) : 1;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] POS_LAST = CW'(In_Dim - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(Pool_Dim - 1);

  if ((In_Dim % Pool_Dim) != 0) begin : g_bad_dim
    $error("relu_pool_requant: In_Dim must be a multiple of Pool_Dim");
  end
  if ((Shift < 0) || (Shift > 15)) begin : g_bad_shift
    $error("relu_pool_requant: Shift must be in 0..15");
  end

  logic [CW-1:0] col, row;
  // Phase-within-window and window index are tracked directly, avoiding divide/modulo on the counters.
  logic [PW-1:0] col_ph, row_ph;
  logic [IW-1:0] win_idx;
  logic [15:0]   max_buf [NW];

  logic          win_start, win_end, last_pix, sat;
  logic [15:0]   cur, m, q;
  logic [7:0]    q_sat;

  always_comb begin
    win_start = (row_ph == '0) && (col_ph == '0);
    win_end   = (row_ph == PH_LAST) && (col_ph == PH_LAST);
    last_pix  = (row == POS_LAST) && (col == POS_LAST);
    cur       = max_buf[win_idx];
    m         = in_pixel;
    if (!win_start && (cur > in_pixel)) begin
      m = cur;
    end
    q     = m >> Shift;
    sat   = |q[15:8];
    q_sat = sat ? 8'hFF : q[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      win_idx    <= '0;
      out_pixel  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < NW; i++) begin
        max_buf[i] <= '0;
      end
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        col     <= '0;
        row     <= '0;
        col_ph  <= '0;
        row_ph  <= '0;
        win_idx <= '0;
      end else if (in_valid) begin
        max_buf[win_idx] <= m;
        if (win_end) begin
          out_pixel  <= q_sat;
          out_valid  <= 1'b1;
          frame_done <= last_pix;
        end
        if (col == POS_LAST) begin
          col     <= '0;
          col_ph  <= '0;
          win_idx <= '0;
          if (row == POS_LAST) begin
            row    <= '0;
            row_ph <= '0;
          end else begin
            row    <= row + 1'b1;
            row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
          if (col_ph == PH_LAST) begin
            col_ph  <= '0;
            win_idx <= win_idx + 1'b1;
          end else begin
            col_ph <= col_ph + 1'b1;
          end
        end
      end
    end
  end

`ifdef POOL_SAT_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count <= '0;
    end else if (clear) begin
      sat_count <= '0;
    end else if (in_valid && win_end && sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_relu_pool_requant.sv
// Self-checking bench for relu_pool_requant: table vectors, directed corner sequences and random
// stimulus checked every cycle against a window-max reference model.
module tb_relu_pool_requant;
  localparam int IN = 4;
  localparam int P  = 2;
  localparam int S  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_pixel;
  logic        in_valid;
  logic        clear;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        frame_done;
`ifdef POOL_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  relu_pool_requant #(.In_Dim(IN), .Pool_Dim(P), .Shift(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .clear      (clear),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .frame_done (frame_done)
`ifdef POOL_SAT_COUNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  int fd_q[$];

  // reference model state: position in frame and the frame image seen so far
  int         pos = 0;
  int         img [IN][IN];
  logic       exp_v, exp_d;
  logic [7:0] exp_p;
  int         sat_m;

  typedef struct {
    logic [15:0] px;
    logic        v;
    logic [7:0]  p;
    logic        d;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model(input logic v, input logic [15:0] px, input logic clr);
    int r, c, m, q;
    exp_v = 1'b0;
    exp_d = 1'b0;
    if (clr) begin
      pos   = 0;
      sat_m = 0;
    end else if (v) begin
      r = pos / IN;
      c = pos % IN;
      img[r][c] = int'(px);
      if ((r % P == P - 1) && (c % P == P - 1)) begin
        m = 0;
        for (int i = r - P + 1; i <= r; i++)
          for (int j = c - P + 1; j <= c; j++)
            if (img[i][j] > m) m = img[i][j];
        q     = m >>> S;
        exp_p = (q > 255) ? 8'hFF : q[7:0];
        exp_v = 1'b1;
        exp_d = (pos == IN * IN - 1);
        if (q > 255 && sat_m < 65535) sat_m++;
      end
      pos = (pos + 1) % (IN * IN);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] px, input logic clr);
    in_valid = v;
    in_pixel = px;
    clear    = clr;
    @(posedge clk);
    model(v, px, clr);
    cyc++;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    chk("out_pixel", {24'b0, out_pixel}, {24'b0, exp_p});
    chk("frame_done", {31'b0, frame_done}, {31'b0, exp_d});
`ifdef POOL_SAT_COUNT_EN
    chk("sat_count", {16'b0, sat_count}, sat_m);
`endif
    if (out_valid) n_out++;
    if (frame_done) fd_q.push_back(cyc);
  endtask

  task automatic frame_ramp(input logic down);
    for (int i = 0; i < 16; i++)
      step(1'b1, down ? 16'(16 * (15 - i)) : 16'(16 * i), 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_out_pixel", {24'b0, out_pixel}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
`ifdef POOL_SAT_COUNT_EN
    chk("rst_sat_count", {16'b0, sat_count}, 0);
`endif
    pos      = 0;
    exp_p    = '0;
    exp_v    = 1'b0;
    exp_d    = 1'b0;
    sat_m    = 0;
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    in_pixel = '0;
    exp_p    = '0;
    exp_v    = 1'b0;
    exp_d    = 1'b0;
    sat_m    = 0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].px = 16'(16 * i);
      tbl[i].v  = 1'b0;
      tbl[i].p  = 8'd0;
      tbl[i].d  = 1'b0;
    end
    tbl[5]  = '{16'd80,  1'b1, 8'd5,  1'b0};
    tbl[7]  = '{16'd112, 1'b1, 8'd7,  1'b0};
    tbl[13] = '{16'd208, 1'b1, 8'd13, 1'b0};
    tbl[15] = '{16'd240, 1'b1, 8'd15, 1'b1};

    // reset state
    #12;
    chk("init_out_pixel", {24'b0, out_pixel}, 0);
    chk("init_out_valid", {31'b0, out_valid}, 0);
    chk("init_frame_done", {31'b0, frame_done}, 0);
    rst = 1'b1;

    // 1: ramp frame, table-driven
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tbl[i].px, 1'b0);
      chk("t1_valid", {31'b0, out_valid}, {31'b0, tbl[i].v});
      if (tbl[i].v) chk("t1_pixel", {24'b0, out_pixel}, {24'b0, tbl[i].p});
      chk("t1_done", {31'b0, frame_done}, {31'b0, tbl[i].d});
    end

    // 2: full-scale input saturates
    n_out = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 16'hFFFF, 1'b0);
    chk("t2_outs", n_out, 4);
    chk("t2_pixel", {24'b0, out_pixel}, 255);
`ifdef POOL_SAT_COUNT_EN
    chk("t2_sat", {16'b0, sat_count}, 4);
`endif

    // 3: in_valid toggling
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'(16 * i), 1'b0);
      step(1'b0, 16'($urandom), 1'b0);
    end
    chk("t3_outs", n_out, 4);

    // 4: back-to-back frames
    fd_q.delete();
    frame_ramp(1'b0);
    frame_ramp(1'b1);
    chk("t4_fd_count", fd_q.size(), 2);
    if (fd_q.size() == 2) chk("t4_fd_gap", fd_q[1] - fd_q[0], 16);

    // 5: clear mid-frame, with a large pixel dropped by the clear
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16 * i), 1'b0);
    step(1'b1, 16'hFFFF, 1'b1);
    n_out = 0;
    frame_ramp(1'b0);
    chk("t5_outs", n_out, 4);
    chk("t5_last", {24'b0, out_pixel}, 15);

    // 6: async reset mid-frame
    for (int i = 0; i < 9; i++) step(1'b1, 16'(16 * i), 1'b0);
    chk("t6_pre_pixel", {24'b0, out_pixel}, 7);
    pulse_reset();
    n_out = 0;
    frame_ramp(1'b0);
    chk("t6_outs", n_out, 4);

    // random traffic with occasional clears
    for (int k = 0; k < 400; k++) begin
      logic [15:0] px;
      px = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(4000, 65535)) : 16'($urandom_range(0, 4095));
      step($urandom_range(0, 3) != 0, px, $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
